// File: rtl/mem_load_ctrl.sv
// Load-port controller: issues memory reads with zero request latency and
// buffers fixed-latency results in an order-preserving FIFO.
// Optional same-cycle result bypass is enabled by defining MEM_LOAD_CTRL_BYPASS_EN.
module mem_load_ctrl #(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned ADDR_TYPE = 32,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_TYPE-1:0] addrIn,
  input  logic                 addrIn_valid,
  output logic                 addrIn_ready,
  output logic [DATA_TYPE-1:0] dataOut,
  output logic                 dataOut_valid,
  input  logic                 dataOut_ready,
  output logic                 loadEn,
  output logic [ADDR_TYPE-1:0] loadAddr,
  input  logic [DATA_TYPE-1:0] memData
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [OCC_W-1:0]     occ;
  logic [OCC_W-1:0]     fifoCnt;
  logic [PTR_W-1:0]     wrPtr;
  logic [PTR_W-1:0]     rdPtr;
  logic [DATA_TYPE-1:0] fifoMem [DEPTH];
  logic [LATENCY-1:0]   inFlight;

  logic accept;
  logic arrive;
  logic fifoEmpty;
  logic fifoPush;
  logic fifoPop;
  logic outFire;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on the occupancy register; gated low while in reset.
  assign addrIn_ready = !rst && (occ < OCC_W'(DEPTH));
  assign accept       = addrIn_valid && addrIn_ready;
  assign loadEn       = accept;
  assign loadAddr     = addrIn;

  assign arrive    = inFlight[LATENCY-1];
  assign fifoEmpty = (fifoCnt == '0);
  assign fifoPop   = !fifoEmpty && dataOut_ready;
  assign outFire   = dataOut_valid && dataOut_ready;

`ifdef MEM_LOAD_CTRL_BYPASS_EN
  // An arriving result is shown immediately when nothing is queued ahead of it.
  assign dataOut_valid = !fifoEmpty || arrive;
  assign dataOut       = !fifoEmpty ? fifoMem[rdPtr] : (arrive ? memData : '0);
  assign fifoPush      = arrive && !(fifoEmpty && dataOut_ready);
`else
  assign dataOut_valid = !fifoEmpty;
  assign dataOut       = fifoEmpty ? '0 : fifoMem[rdPtr];
  assign fifoPush      = arrive;
`endif

  // Control state: read-tracking shift register, occupancy and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inFlight <= '0;
      occ      <= '0;
      fifoCnt  <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else begin
      inFlight <= LATENCY'({inFlight, accept});

      case ({accept, outFire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      case ({fifoPush, fifoPop})
        2'b10:   fifoCnt <= fifoCnt + OCC_W'(1);
        2'b01:   fifoCnt <= fifoCnt - OCC_W'(1);
        default: fifoCnt <= fifoCnt;
      endcase

      if (fifoPush) wrPtr <= ptrInc(wrPtr);
      if (fifoPop)  rdPtr <= ptrInc(rdPtr);
    end
  end

  // Storage needs no reset: entries are only visible through fifoCnt.
  always_ff @(posedge clk) begin
    if (fifoPush) fifoMem[wrPtr] <= memData;
  end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Scoreboard bench for mem_load_ctrl: a fixed-latency memory model answers
// loads, expected read data is queued at issue and checked by a monitor.
module tb_mem_load_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 4;
`ifdef MEM_LOAD_CTRL_BYPASS_EN
  localparam int unsigned VLD_LAT = LAT;
`else
  localparam int unsigned VLD_LAT = LAT + 1;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] addrIn;
  logic          addrIn_valid;
  logic          addrIn_ready;
  logic [DW-1:0] dataOut;
  logic          dataOut_valid;
  logic          dataOut_ready;
  logic          loadEn;
  logic [AW-1:0] loadAddr;
  logic [DW-1:0] memData;

  int vecs = 0;
  int errs = 0;
  logic [DW-1:0] expQ [$];

  mem_load_ctrl #(
    .DATA_TYPE(DW), .ADDR_TYPE(AW), .LATENCY(LAT), .DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .addrIn(addrIn), .addrIn_valid(addrIn_valid), .addrIn_ready(addrIn_ready),
    .dataOut(dataOut), .dataOut_valid(dataOut_valid), .dataOut_ready(dataOut_ready),
    .loadEn(loadEn), .loadAddr(loadAddr), .memData(memData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x10 holds 0xAB, otherwise {lo16 ^ hi16 ^ 0x5A5A, lo16}.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hAB;
    return {a[15:0] ^ a[31:16] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Fixed-latency memory; it keeps answering across a controller reset.
  logic          pv [LAT];
  logic [AW-1:0] pa [LAT];
  always @(posedge clk) begin
    pv[0] <= loadEn;
    pa[0] <= loadAddr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign memData = pv[LAT-1] ? memf(pa[LAT-1]) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && dataOut_valid && dataOut_ready) begin
      if (expQ.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_output: got %0h expected none", dataOut);
      end else begin
        chk("dataOut", 64'(dataOut), 64'(expQ.pop_front()));
      end
    end
  end

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && expQ.size() != 0; k++) @(negedge clk);
    chk(nm, 64'(expQ.size()), 64'd0);
  endtask

  logic [DW-1:0] streamExp [8] = '{32'h5A5A0000, 32'h5A5B0001, 32'h5A580002, 32'h5A590003,
                                   32'h5A5E0004, 32'h5A5F0005, 32'h5A5C0006, 32'h5A5D0007};
  logic [DW-1:0] bpExp [DEP] = '{32'h5A7A0020, 32'h5A7B0021, 32'h5A780022, 32'h5A790023};

  initial begin
    int lat;
    rst = 1'b1;
    addrIn = '0;
    addrIn_valid = 1'b0;
    dataOut_ready = 1'b0;

    // Reset values, with a pending request that must be ignored
    repeat (2) @(negedge clk);
    addrIn_valid = 1'b1;
    addrIn = 32'h99;
    dataOut_ready = 1'b1;
    #1;
    chk("rst_addrIn_ready", 64'(addrIn_ready), 64'd0);
    chk("rst_dataOut_valid", 64'(dataOut_valid), 64'd0);
    chk("rst_loadEn", 64'(loadEn), 64'd0);
    chk("rst_dataOut", 64'(dataOut), 64'd0);
    addrIn_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(addrIn_ready), 64'd1);

    // Single load and output latency
    @(posedge clk); #1;
    addrIn = 32'h10;
    addrIn_valid = 1'b1;
    expQ.push_back(32'hAB);
    @(negedge clk);
    chk("single_loadEn", 64'(loadEn), 64'd1);
    chk("single_loadAddr", 64'(loadAddr), 64'h10);
    @(posedge clk); #1;
    addrIn_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (dataOut_valid) lat = k;
      else @(negedge clk);
    end
    chk("single_latency", 64'(lat), 64'(VLD_LAT));
    repeat (2) @(negedge clk);
    chk("single_one_beat", 64'(dataOut_valid), 64'd0);

    // Streaming: one accept per cycle with the output always ready
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      addrIn = AW'(i);
      addrIn_valid = 1'b1;
      expQ.push_back(streamExp[i]);
      @(negedge clk);
      chk($sformatf("stream_accept%0d", i), 64'(loadEn), 64'd1);
    end
    @(posedge clk); #1;
    addrIn_valid = 1'b0;
    drain("stream_drain");

    // Backpressure: only DEPTH loads fit while the output is stalled
    for (int i = 0; i < int'(DEP) + 2; i++) begin
      @(posedge clk); #1;
      dataOut_ready = 1'b0;
      addrIn = AW'(32'h20 + i);
      addrIn_valid = 1'b1;
      if (i < int'(DEP)) expQ.push_back(bpExp[i]);
      @(negedge clk);
      chk($sformatf("bp_loadEn%0d", i), 64'(loadEn), (i < int'(DEP)) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    addrIn_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("bp_hold_valid", 64'(dataOut_valid), 64'd1);
    chk("bp_hold_data", 64'(dataOut), 64'h5A7A0020);
    repeat (2) @(negedge clk);
    chk("bp_stable_data", 64'(dataOut), 64'h5A7A0020);
    chk("bp_ready_low", 64'(addrIn_ready), 64'd0);
    @(posedge clk); #1;
    dataOut_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_during_pop", 64'(addrIn_ready), 64'd0);
    @(posedge clk); #1;
    dataOut_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_reraised", 64'(addrIn_ready), 64'd1);

    // Accept and pop together at DEPTH-1: occupancy must stay put
    @(posedge clk); #1;
    addrIn = 32'h30;
    addrIn_valid = 1'b1;
    dataOut_ready = 1'b1;
    expQ.push_back(32'h5A6A0030);
    @(negedge clk);
    chk("sim_loadEn", 64'(loadEn), 64'd1);
    @(posedge clk); #1;
    addrIn = 32'h31;
    dataOut_ready = 1'b0;
    @(negedge clk);
    chk("sim_ready_kept", 64'(addrIn_ready), 64'd1);
    chk("sim_loadEn2", 64'(loadEn), 64'd1);
    expQ.push_back(32'h5A6B0031);
    @(posedge clk); #1;
    addrIn_valid = 1'b0;
    @(negedge clk);
    chk("sim_full", 64'(addrIn_ready), 64'd0);
    @(posedge clk); #1;
    dataOut_ready = 1'b1;
    drain("sim_drain");

    // Reset with two reads in flight: stale memory data must be dropped
    @(posedge clk); #1;
    addrIn = 32'h50;
    addrIn_valid = 1'b1;
    @(negedge clk);
    chk("rf_accept0", 64'(loadEn), 64'd1);
    @(posedge clk); #1;
    addrIn = 32'h51;
    @(negedge clk);
    chk("rf_accept1", 64'(loadEn), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rf_addrIn_ready", 64'(addrIn_ready), 64'd0);
    chk("rf_dataOut_valid", 64'(dataOut_valid), 64'd0);
    chk("rf_loadEn", 64'(loadEn), 64'd0);
    chk("rf_dataOut", 64'(dataOut), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    addrIn_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rf_no_stale%0d", k), 64'(dataOut_valid), 64'd0);
    end

    // Normal operation resumes after the mid-flight reset
    @(posedge clk); #1;
    addrIn = 32'h40;
    addrIn_valid = 1'b1;
    expQ.push_back(32'h5A1A0040);
    @(negedge clk);
    chk("post_rst_loadEn", 64'(loadEn), 64'd1);
    @(posedge clk); #1;
    addrIn_valid = 1'b0;
    drain("post_rst_drain");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_TYPE, default 32: width of read data.
REQ-002 The block SHALL have parameter ADDR_TYPE, default 32: width of read address.
REQ-003 The block SHALL have parameter LATENCY, default 1: fixed memory read latency in cycles; legal values are 1 to 8.
REQ-004 The block SHALL have parameter DEPTH, default 2: maximum number of loads that are in flight or buffered at once; legal values are 1 to 16.
REQ-005 The block SHALL have one clock, clk; reset SHALL be rst, asynchronous and active-high.
REQ-006 The block SHALL have the following ports, clock and reset first:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- addrIn  input  ADDR_TYPE  load address from the load port
- addrIn_valid  input  1  address valid
- addrIn_ready  output  1  address accepted
- dataOut  output  DATA_TYPE  read data to the load port
- dataOut_valid  output  1  read data valid
- dataOut_ready  input  1  load port accepts data
- loadEn  output  1  memory read enable
- loadAddr  output  ADDR_TYPE  memory read address
- memData  input  DATA_TYPE  memory read data, valid LATENCY cycles after loadEn

Function
REQ-007 An address SHALL be accepted in a cycle where addrIn_valid and addrIn_ready are both 1.
REQ-008 loadEn SHALL equal the accept condition in the same cycle, and loadAddr SHALL equal addrIn, so there is no added request latency.
REQ-009 A LATENCY-stage valid shift register SHALL mark the cycle in which memData carries the result of each accepted read.
REQ-010 When a tagged result arrives, it SHALL be written into a DEPTH-entry FIFO that preserves order.
REQ-011 Occupancy SHALL be the number of reads in flight plus the number of FIFO entries; it SHALL be a registered counter of width $clog2(DEPTH+1).
REQ-012 addrIn_ready SHALL be 1 exactly when occupancy < DEPTH, and SHALL be driven from registers only (no combinational path from addrIn_valid or dataOut_ready).
REQ-013 Occupancy SHALL increment on an accept and decrement on a dataOut handshake; if both happen in the same cycle, occupancy SHALL be unchanged.
REQ-014 dataOut_valid SHALL be 1 whenever the FIFO is non-empty, and dataOut SHALL show the FIFO head.
REQ-015 dataOut and dataOut_valid SHALL hold stable while dataOut_ready is 0.
REQ-016 With the bypass feature absent and no backpressure, dataOut_valid SHALL rise LATENCY+1 cycles after the accept.
REQ-017 The FIFO SHALL never overflow; this is guaranteed by REQ-012, because memory results cannot be stalled.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH.
REQ-019 When the FIFO is full and a pop occurs in the same cycle as a push, both operations SHALL complete.
REQ-020 Back-to-back accepts SHALL be sustained at one per cycle when DEPTH >= LATENCY+1 and dataOut_ready is held at 1.

Reset
REQ-021 On rst, occupancy, the shift register and the FIFO pointers SHALL clear.
REQ-022 During reset, addrIn_ready, dataOut_valid and loadEn SHALL be 0, and dataOut SHALL be 0.
REQ-023 After reset deasserts, addrIn_ready SHALL be 1 in the first cycle.
REQ-024 A reset applied mid-operation SHALL discard all in-flight reads; memData returning after reset SHALL be ignored.

Configuration
REQ-025 The bypass feature SHALL be controlled by the macro MEM_LOAD_CTRL_BYPASS_EN.
REQ-026 With MEM_LOAD_CTRL_BYPASS_EN defined, a result that arrives while the FIFO is empty SHALL drive dataOut and dataOut_valid in the same cycle (latency LATENCY).
- The result SHALL be written into the FIFO only if dataOut_ready is 0 in that cycle.
REQ-027 With MEM_LOAD_CTRL_BYPASS_EN undefined, results SHALL always pass through the FIFO, per REQ-016.

Verification
REQ-028 Single load, LATENCY=1, no bypass: addrIn=0x10 accepted with memData=0xAB one cycle later -> loadEn=1 and loadAddr=0x10 in the accept cycle, and dataOut=0xAB with dataOut_valid=1 two cycles after the accept.
REQ-029 Streaming, LATENCY=2, DEPTH=3, dataOut_ready=1, addresses 0..7 -> eight accepts in eight consecutive cycles, and data returns in order.
REQ-030 Backpressure, DEPTH=2, dataOut_ready=0 -> addrIn_ready=0 after two accepts; raising dataOut_ready pops one entry and re-raises addrIn_ready the next cycle.
REQ-031 Simultaneous accept and pop at occupancy=DEPTH-1 -> occupancy is unchanged and no data is lost or duplicated.
REQ-032 Reset asserted with 2 reads in flight -> all outputs are 0 and stale memData never appears on dataOut.
REQ-033 Bypass build, LATENCY=1 -> dataOut_valid=1 exactly one cycle after the accept, carrying the value of memData.
